// File: rtl/l2_cpu_issuer_pkg.sv
// Shared types for the CPU-side L2 issuer: bus widths, message/response codes and the l2_cpu_req_t bundle.
// 64-bit words, 128-bit lines (two words per line); the word offset is addr[3].
package l2_cpu_issuer_pkg;

   localparam int ADDR_BITS      = 32;
   localparam int BITS_PER_WORD  = 64;
   localparam int WORDS_PER_LINE = 2;
   localparam int BITS_PER_LINE  = BITS_PER_WORD * WORDS_PER_LINE;
   localparam int W_OFF_LO       = 3;
   localparam int W_OFF_W        = 1;
   localparam int LINE_ADDR_BITS = 28;
   localparam int AMO_BITS       = 6;
   localparam int HSIZE_BITS     = 3;
   localparam int HPROT_WIDTH    = 2;
   localparam int BRESP_BITS     = 2;

   typedef logic [ADDR_BITS-1:0]      addr_t;
   typedef logic [BITS_PER_WORD-1:0]  word_t;
   typedef logic [BITS_PER_LINE-1:0]  line_t;
   typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
   typedef logic [AMO_BITS-1:0]       amo_t;
   typedef logic [HSIZE_BITS-1:0]     hsize_t;
   typedef logic [HPROT_WIDTH-1:0]    hprot_t;
   typedef logic [W_OFF_W-1:0]        w_off_t;

   typedef enum logic [1:0] {
      CPU_READ      = 2'd0,
      CPU_READ_ATOM = 2'd1,
      CPU_WRITE     = 2'd2
   } cpu_msg_t;

   typedef enum logic [BRESP_BITS-1:0] {
      BRESP_OKAY   = 2'd0,
      BRESP_EXOKAY = 2'd1,
      BRESP_SLVERR = 2'd2,
      BRESP_DECERR = 2'd3
   } bresp_t;

   typedef struct packed {
      cpu_msg_t cpu_msg;
      hsize_t   hsize;
      hprot_t   hprot;
      addr_t    addr;
      word_t    word;
      amo_t     amo;
   } l2_cpu_req_t;

   function automatic w_off_t word_off(input addr_t a);
      return a[W_OFF_LO +: W_OFF_W];
   endfunction

endpackage

// File: rtl/l2_cpu_issuer_word_sel.sv
// Picks one word out of an L2 line by word offset.
// Purely combinational; no handshake.
module l2_cpu_issuer_word_sel
   import l2_cpu_issuer_pkg::*;
(
   input  logic [BITS_PER_LINE-1:0] line_i,
   input  logic [W_OFF_W-1:0]       off_i,
   output logic [BITS_PER_WORD-1:0] word_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         if (off_i == w_off_t'(i)) word_o = line_i[i*BITS_PER_WORD +: BITS_PER_WORD];
      end
   end

endmodule

// File: rtl/l2_cpu_issuer.sv
// One-outstanding CPU -> L2 request issuer; accept-to-response 3 cycles with zero-wait L2, all handshakes registered.
// Optional completion watchdog under L2_ISSUER_TIMEOUT_EN; invalidations are always sunk and counted.
module l2_cpu_issuer
   import l2_cpu_issuer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int INVAL_CNT_W    = 16
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_req_write,
   input  logic [AMO_BITS-1:0]       cpu_req_amo,
   input  logic [ADDR_BITS-1:0]      cpu_req_addr,
   input  logic [HSIZE_BITS-1:0]     cpu_req_hsize,
   input  logic [HPROT_WIDTH-1:0]    cpu_req_hprot,
   input  logic [BITS_PER_WORD-1:0]  cpu_req_wdata,
   output logic                      cpu_rsp_valid,
   input  logic                      cpu_rsp_ready,
   output logic [BITS_PER_WORD-1:0]  cpu_rsp_rdata,
   output logic                      cpu_rsp_err,
   output logic                      l2_cpu_req_valid,
   input  logic                      l2_cpu_req_ready,
   output l2_cpu_req_t               l2_cpu_req_o,
   input  logic                      l2_rd_rsp_valid,
   output logic                      l2_rd_rsp_ready,
   input  logic [BITS_PER_LINE-1:0]  l2_rd_rsp_line,
   input  logic                      l2_bresp_valid,
   output logic                      l2_bresp_ready,
   input  logic [BRESP_BITS-1:0]     l2_bresp,
   input  logic                      l2_inval_valid,
   output logic                      l2_inval_ready,
   input  logic [LINE_ADDR_BITS-1:0] l2_inval_addr,
   output logic [INVAL_CNT_W-1:0]    inval_cnt,
   output logic                      spurious
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_WAIT_BR, ST_RESP
   } issuer_state_t;

   issuer_state_t            state_q, state_d;
   l2_cpu_req_t              req_q;
   logic                     cpu_req_ready_q, l2_req_valid_q, rsp_valid_q;
   logic                     rd_rsp_ready_q, bresp_ready_q, inval_ready_q;
   logic [BITS_PER_WORD-1:0] rdata_q;
   logic                     err_q, spurious_q;
   logic [INVAL_CNT_W-1:0]   inval_cnt_q;
   logic [BITS_PER_WORD-1:0] sel_word;
   logic                     rd_beat, br_beat, accept, tmo_hit, waiting;
   logic                     unused_inval_addr;

   assign unused_inval_addr = ^l2_inval_addr;

   assign rd_beat = l2_rd_rsp_valid & rd_rsp_ready_q;
   assign br_beat = l2_bresp_valid & bresp_ready_q;
   assign accept  = (state_q == ST_IDLE) & cpu_req_valid & cpu_req_ready_q;
   assign waiting = (state_q == ST_WAIT_RD) | (state_q == ST_WAIT_BR);

`ifdef L2_ISSUER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] tmo_q;

   assign tmo_hit = waiting & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_q <= '0;
      end else if (state_q == ST_ISSUE) begin
         tmo_q <= '0;
      end else if (waiting && !tmo_hit) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   l2_cpu_issuer_word_sel u_word_sel (
      .line_i (l2_rd_rsp_line),
      .off_i  (word_off(req_q.addr)),
      .word_o (sel_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_ISSUE;
         ST_ISSUE:   if (l2_cpu_req_ready)
                        state_d = (req_q.cpu_msg == CPU_WRITE) ? ST_WAIT_BR : ST_WAIT_RD;
         ST_WAIT_RD: if (rd_beat || tmo_hit) state_d = ST_RESP;
         ST_WAIT_BR: if (br_beat || tmo_hit) state_d = ST_RESP;
         ST_RESP:    if (cpu_rsp_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next state's decode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         req_q           <= '0;
         cpu_req_ready_q <= 1'b0;
         l2_req_valid_q  <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rd_rsp_ready_q  <= 1'b0;
         bresp_ready_q   <= 1'b0;
         inval_ready_q   <= 1'b0;
         rdata_q         <= '0;
         err_q           <= 1'b0;
         spurious_q      <= 1'b0;
         inval_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         cpu_req_ready_q <= (state_d == ST_IDLE);
         l2_req_valid_q  <= (state_d == ST_ISSUE);
         rsp_valid_q     <= (state_d == ST_RESP);
         rd_rsp_ready_q  <= (state_d != ST_ISSUE) && (state_d != ST_RESP);
         bresp_ready_q   <= (state_d != ST_ISSUE) && (state_d != ST_RESP);
         inval_ready_q   <= 1'b1;

         if (accept) begin
            req_q.cpu_msg <= (cpu_req_amo != '0) ? CPU_READ_ATOM :
                             (cpu_req_write ? CPU_WRITE : CPU_READ);
            req_q.hsize   <= cpu_req_hsize;
            req_q.hprot   <= cpu_req_hprot;
            req_q.addr    <= cpu_req_addr;
            req_q.word    <= cpu_req_wdata;
            req_q.amo     <= cpu_req_amo;
         end

         if (state_q == ST_WAIT_RD && rd_beat) begin
            rdata_q <= sel_word;
            err_q   <= 1'b0;
         end else if (state_q == ST_WAIT_BR && br_beat) begin
            rdata_q <= '0;
            err_q   <= (l2_bresp != BRESP_OKAY);
         end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end

         if ((rd_beat && state_q != ST_WAIT_RD) || (br_beat && state_q != ST_WAIT_BR))
            spurious_q <= 1'b1;

         if (l2_inval_valid && inval_ready_q && !(&inval_cnt_q))
            inval_cnt_q <= inval_cnt_q + 1'b1;
      end
   end

   assign cpu_req_ready    = cpu_req_ready_q;
   assign cpu_rsp_valid    = rsp_valid_q;
   assign cpu_rsp_rdata    = rdata_q;
   assign cpu_rsp_err      = err_q;
   assign l2_cpu_req_valid = l2_req_valid_q;
   assign l2_cpu_req_o     = req_q;
   assign l2_rd_rsp_ready  = rd_rsp_ready_q;
   assign l2_bresp_ready   = bresp_ready_q;
   assign l2_inval_ready   = inval_ready_q;
   assign inval_cnt        = inval_cnt_q;
   assign spurious         = spurious_q;

endmodule

// File: tb/tb_l2_cpu_issuer.sv
// Directed bench for l2_cpu_issuer: load/store/AMO flows, backpressure, reset abort, spurious beats, inval saturation.
module tb_l2_cpu_issuer;
   import l2_cpu_issuer_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      cpu_req_valid, cpu_req_ready, cpu_req_write;
   logic [AMO_BITS-1:0]       cpu_req_amo;
   logic [ADDR_BITS-1:0]      cpu_req_addr;
   logic [HSIZE_BITS-1:0]     cpu_req_hsize;
   logic [HPROT_WIDTH-1:0]    cpu_req_hprot;
   logic [BITS_PER_WORD-1:0]  cpu_req_wdata;
   logic                      cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
   logic [BITS_PER_WORD-1:0]  cpu_rsp_rdata;
   logic                      l2_cpu_req_valid, l2_cpu_req_ready;
   l2_cpu_req_t               l2_cpu_req_o;
   logic                      l2_rd_rsp_valid, l2_rd_rsp_ready;
   logic [BITS_PER_LINE-1:0]  l2_rd_rsp_line;
   logic                      l2_bresp_valid, l2_bresp_ready;
   logic [BRESP_BITS-1:0]     l2_bresp;
   logic                      l2_inval_valid, l2_inval_ready;
   logic [LINE_ADDR_BITS-1:0] l2_inval_addr;
   logic [15:0]               inval_cnt;
   logic                      spurious;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   l2_cpu_issuer #(.TIMEOUT_CYCLES(16), .INVAL_CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_write(cpu_req_write), .cpu_req_amo(cpu_req_amo),
      .cpu_req_addr(cpu_req_addr), .cpu_req_hsize(cpu_req_hsize),
      .cpu_req_hprot(cpu_req_hprot), .cpu_req_wdata(cpu_req_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
      .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
      .l2_cpu_req_valid(l2_cpu_req_valid), .l2_cpu_req_ready(l2_cpu_req_ready),
      .l2_cpu_req_o(l2_cpu_req_o),
      .l2_rd_rsp_valid(l2_rd_rsp_valid), .l2_rd_rsp_ready(l2_rd_rsp_ready),
      .l2_rd_rsp_line(l2_rd_rsp_line),
      .l2_bresp_valid(l2_bresp_valid), .l2_bresp_ready(l2_bresp_ready),
      .l2_bresp(l2_bresp),
      .l2_inval_valid(l2_inval_valid), .l2_inval_ready(l2_inval_ready),
      .l2_inval_addr(l2_inval_addr),
      .inval_cnt(inval_cnt), .spurious(spurious)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cpu_req(input logic wr, input logic [AMO_BITS-1:0] amo,
                          input logic [31:0] addr, input logic [63:0] wdata);
      cpu_req_valid = 1'b1;
      cpu_req_write = wr;
      cpu_req_amo   = amo;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      tick();
      cpu_req_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0;
      cpu_req_valid = 0; cpu_req_write = 0; cpu_req_amo = '0; cpu_req_addr = '0;
      cpu_req_hsize = 3'd3; cpu_req_hprot = 2'd1; cpu_req_wdata = '0;
      cpu_rsp_ready = 0; l2_cpu_req_ready = 0;
      l2_rd_rsp_valid = 0; l2_rd_rsp_line = '0;
      l2_bresp_valid = 0; l2_bresp = 2'd0;
      l2_inval_valid = 0; l2_inval_addr = '0;
      tick(); tick();

      chk("rst_req_ready", cpu_req_ready, 0);
      chk("rst_rsp_valid", cpu_rsp_valid, 0);
      chk("rst_l2_valid", l2_cpu_req_valid, 0);
      chk("rst_rdata_err", {cpu_rsp_rdata, cpu_rsp_err}, 0);
      chk("rst_inval_cnt", inval_cnt, 0);
      chk("rst_spurious", spurious, 0);
      chk("rst_inval_ready", l2_inval_ready, 0);

      rst = 1'b1;
      tick();
      chk("idle_req_ready", cpu_req_ready, 1);
      chk("idle_rd_ready", l2_rd_rsp_ready, 1);
      chk("idle_inval_ready", l2_inval_ready, 1);

      // Load from 0x8000_0008 -> word 1 of the returned line.
      cpu_req(1'b0, '0, 32'h8000_0008, '0);
      chk("ld_l2_valid", l2_cpu_req_valid, 1);
      chk("ld_msg", l2_cpu_req_o.cpu_msg, CPU_READ);
      chk("ld_addr", l2_cpu_req_o.addr, 32'h8000_0008);
      chk("ld_req_ready_busy", cpu_req_ready, 0);
      l2_cpu_req_ready = 1;
      tick();
      l2_cpu_req_ready = 0;
      chk("ld_l2_valid_drop", l2_cpu_req_valid, 0);
      tick();
      l2_rd_rsp_valid = 1;
      l2_rd_rsp_line = {64'h0000_0000_DEAD_BEEF, 64'h1111_2222_3333_4444};
      tick();
      l2_rd_rsp_valid = 0;
      chk("ld_rsp_valid", cpu_rsp_valid, 1);
      chk("ld_rdata", cpu_rsp_rdata, 64'hDEAD_BEEF);
      chk("ld_err", cpu_rsp_err, 0);
      chk("ld_rd_ready_resp", l2_rd_rsp_ready, 0);
      cpu_rsp_ready = 1;
      tick();
      cpu_rsp_ready = 0;
      chk("ld_done_valid", cpu_rsp_valid, 0);
      chk("ld_done_ready", cpu_req_ready, 1);

      // Store 0x1234 to 0x100 with OKAY, then a store that gets SLVERR.
      cpu_req(1'b1, '0, 32'h0000_0100, 64'h1234);
      chk("st_msg", l2_cpu_req_o.cpu_msg, CPU_WRITE);
      chk("st_word", l2_cpu_req_o.word, 64'h1234);
      l2_cpu_req_ready = 1;
      tick();
      l2_cpu_req_ready = 0;
      chk("st_br_ready", l2_bresp_ready, 1);
      l2_bresp_valid = 1; l2_bresp = 2'd0;
      tick();
      l2_bresp_valid = 0;
      chk("st_rsp", {cpu_rsp_valid, cpu_rsp_err}, 2'b10);
      chk("st_rdata", cpu_rsp_rdata, 0);
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;

      cpu_req(1'b1, '0, 32'h0000_0108, 64'h0);
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      l2_bresp_valid = 1; l2_bresp = 2'd2;
      tick();
      l2_bresp_valid = 0;
      chk("st_slverr", {cpu_rsp_valid, cpu_rsp_err}, 2'b11);
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;

      // AMO with write=1: atomic wins, waits for rd_rsp; a bresp meanwhile is spurious.
      cpu_req(1'b1, 6'h1, 32'h0000_0200, 64'h5);
      chk("amo_msg", l2_cpu_req_o.cpu_msg, CPU_READ_ATOM);
      chk("amo_fields", {l2_cpu_req_o.amo, l2_cpu_req_o.word}, {6'h1, 64'h5});
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      l2_bresp_valid = 1; l2_bresp = 2'd0;
      tick();
      l2_bresp_valid = 0;
      chk("amo_spurious", spurious, 1);
      chk("amo_still_wait", cpu_rsp_valid, 0);
      l2_rd_rsp_valid = 1;
      l2_rd_rsp_line = {64'hAAAA, 64'h42};
      tick();
      l2_rd_rsp_valid = 0;
      chk("amo_rsp", {cpu_rsp_valid, cpu_rsp_err}, 2'b10);
      chk("amo_rdata", cpu_rsp_rdata, 64'h42);
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;

      // Backpressure on both sides while a second request is held valid.
      cpu_req(1'b0, '0, 32'h4000_0008, '0);
      cpu_req_valid = 1; cpu_req_addr = 32'h0000_0999;
      for (int i = 0; i < 5; i++) begin
         chk("bp_issue_hold", {l2_cpu_req_valid, cpu_req_ready, l2_cpu_req_o.addr},
             {1'b1, 1'b0, 32'h4000_0008});
         tick();
      end
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      l2_rd_rsp_valid = 1;
      l2_rd_rsp_line = {64'h77, 64'h66};
      tick();
      l2_rd_rsp_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_rsp_hold", {cpu_rsp_valid, cpu_req_ready, cpu_rsp_rdata}, {1'b1, 1'b0, 64'h77});
      end
      cpu_rsp_ready = 1;
      tick();
      cpu_rsp_ready = 0; cpu_req_valid = 0;
      chk("bp_no_accept", {cpu_rsp_valid, l2_cpu_req_valid, cpu_req_ready}, 3'b001);
      tick();
      chk("bp_still_idle", l2_cpu_req_valid, 0);

      // Reset mid-transaction, then the stale rd_rsp lands in IDLE.
      cpu_req(1'b0, '0, 32'h0000_0010, '0);
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      rst = 0;
      tick();
      chk("abort_state", {l2_cpu_req_valid, l2_rd_rsp_ready, cpu_rsp_valid, spurious}, 4'b0000);
      rst = 1;
      tick();
      l2_rd_rsp_valid = 1;
      tick();
      l2_rd_rsp_valid = 0;
      chk("late_rd_spurious", {spurious, cpu_rsp_valid}, 2'b10);

      // Invalidation counting with a load running concurrently, then saturation.
      l2_inval_valid = 1;
      l2_inval_addr = 28'h123_4567;
      tick(); tick(); tick();
      chk("inval_cnt3", inval_cnt, 3);
      cpu_req(1'b0, '0, 32'h0000_0018, '0);
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      l2_rd_rsp_valid = 1;
      l2_rd_rsp_line = {64'hCAFE_F00D, 64'h1};
      tick();
      l2_rd_rsp_valid = 0;
      chk("inval_ld_rdata", {cpu_rsp_valid, cpu_rsp_rdata}, {1'b1, 64'hCAFE_F00D});
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;
      chk("inval_cnt7", inval_cnt, 7);
      repeat (70000) tick();
      l2_inval_valid = 0;
      chk("inval_sat", inval_cnt, 16'hFFFF);

`ifdef L2_ISSUER_TIMEOUT_EN
      rst = 0; tick(); rst = 1; tick();
      cpu_req(1'b0, '0, 32'h0000_0008, '0);
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      n = 0;
      while (!cpu_rsp_valid && n < 100) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, 16);
      chk("tmo_rsp", {cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata}, {1'b1, 1'b1, 64'h0});
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;
      l2_rd_rsp_valid = 1; tick(); l2_rd_rsp_valid = 0;
      chk("tmo_late_spurious", spurious, 1);
`else
      cpu_req(1'b0, '0, 32'h0000_0008, '0);
      l2_cpu_req_ready = 1; tick(); l2_cpu_req_ready = 0;
      n = 0;
      while (!cpu_rsp_valid && n < 40) begin
         tick();
         n++;
      end
      chk("notmo_waits", {cpu_rsp_valid, l2_rd_rsp_ready}, 2'b01);
      l2_rd_rsp_valid = 1;
      l2_rd_rsp_line = {64'hBEEF, 64'h0};
      tick();
      l2_rd_rsp_valid = 0;
      chk("notmo_rsp", {cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata}, {1'b1, 1'b0, 64'hBEEF});
      cpu_rsp_ready = 1; tick(); cpu_rsp_ready = 0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
